// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame-buffer read path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package vga_pkg;

  typedef enum logic {
    SCALE_1X = 1'b0,
    SCALE_2X = 1'b1
  } scale_mode_e;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int CH_W     = 4;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that carries flags alongside the BRAM read.
// Latency: DEPTH clocks from d to q.
// Backpressure: none, it advances on every clock.
module vga_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/vga_fb_scaler_reader.sv
// Frame-buffer read controller: screen coordinates to BRAM address, 1:1 or 2x doubling.
// Latency: RD_LAT+2 clocks from coordinate to RGB and delayed syncs, in both modes.
// Backpressure: none, it follows the pixel clock unconditionally.
module vga_fb_scaler_reader
  import vga_pkg::*;
#(
  parameter int             IMG_W    = 320,
  parameter int             IMG_H    = 240,
  parameter int             PIX_W    = 12,
  parameter int             ADDR_W   = 17,
  parameter int             RD_LAT   = 1,
  parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        x_coor,
  input  logic [8:0]        y_coor,
  input  logic              display_en,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic              mode,
  output logic              re,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [PIX_W-1:0]  rData,
  output logic [PIX_W/3-1:0] vgaRed,
  output logic [PIX_W/3-1:0] vgaGreen,
  output logic [PIX_W/3-1:0] vgaBlue,
  output logic              h_sync_o,
  output logic              v_sync_o
);

  localparam int CW = PIX_W / 3;

  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] line_start;
  logic [ADDR_W-1:0] eff;
  logic              mode_q;
  logic              synced;
  scale_mode_e       scale;
  logic              frame_start;
  logic              synced_eff;
  logic              act;
  logic              border;
  logic [10:0]       x_lim;
  logic [9:0]        y_lim;
  logic              act_d, border_d, hs_d, vs_d;
  logic [PIX_W-1:0]  rgb_q;

  // The frame_start pixel already uses the freshly sampled mode and counts as synced.
  always_comb begin
    frame_start = display_en && (x_coor == '0) && (y_coor == '0);
    scale       = scale_mode_e'(frame_start ? mode : mode_q);
    synced_eff  = synced || frame_start;
    x_lim       = (scale == SCALE_2X) ? 11'(2*IMG_W) : 11'(IMG_W);
    y_lim       = (scale == SCALE_2X) ? 10'(2*IMG_H) : 10'(IMG_H);
    act         = display_en && synced_eff && ({1'b0, x_coor} < x_lim) && ({1'b0, y_coor} < y_lim);
    border      = display_en && synced_eff;
    eff         = frame_start ? '0 : addr_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_cnt   <= '0;
      line_start <= '0;
      mode_q     <= 1'b0;
      synced     <= 1'b0;
      re         <= 1'b0;
      rAddr      <= '0;
    end else begin
      if (frame_start) begin
        mode_q <= mode;
        synced <= 1'b1;
      end
      re    <= act;
      rAddr <= act ? eff : '0;
      if (act) begin
        if (scale == SCALE_1X) begin
          addr_cnt <= eff + ADDR_W'(1);
        end else begin
          if (x_coor == '0) line_start <= eff;
          // Even line ends by rewinding, so the odd line re-reads the same source line.
          if ((x_coor == 10'(2*IMG_W-1)) && !y_coor[0])
            addr_cnt <= line_start;
          else
            addr_cnt <= eff + ADDR_W'(x_coor[0]);
        end
      end
    end
  end

  vga_delay_line #(
    .W     (4),
    .DEPTH (RD_LAT + 1)
  ) u_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({act, border, h_sync, v_sync}),
    .q       ({act_d, border_d, hs_d, vs_d})
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q    <= '0;
      h_sync_o <= 1'b0;
      v_sync_o <= 1'b0;
    end else begin
      rgb_q    <= act_d ? rData : (border_d ? BG_COLOR : '0);
      h_sync_o <= hs_d;
      v_sync_o <= vs_d;
    end
  end

  assign vgaRed   = rgb_q[PIX_W-1 -: CW];
  assign vgaGreen = rgb_q[PIX_W-1-CW -: CW];
  assign vgaBlue  = rgb_q[CW-1:0];

endmodule

// File: tb/tb_vga_fb_scaler_reader.sv
// Bench for vga_fb_scaler_reader: two builds (RD_LAT 1 and 3) on a reduced 32x24 image,
// driven by directed frames and checked against coordinate-derived addresses and a BRAM model.
module tb_vga_fb_scaler_reader;
  import vga_pkg::*;

  localparam int         IW = 32;
  localparam int         IH = 24;
  localparam logic [11:0] BG = 12'hF0F;
  localparam int         LA = 2;
  localparam int         LB = 4;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  x_coor;
  logic [8:0]  y_coor;
  logic        display_en, h_sync, v_sync, mode;

  logic        re_a, re_b;
  logic [16:0] raddr_a, raddr_b;
  logic [11:0] rdata_a, rdata_b;
  logic [3:0]  red_a, grn_a, blu_a, red_b, grn_b, blu_b;
  logic        hso_a, vso_a, hso_b, vso_b;
  logic [11:0] p3 [3];

  exp_t qa[$];
  exp_t qb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic mode_m = 1'b0;
  logic synced_m = 1'b0;
  int   rst_cnt = 0;

  always #5 clk = ~clk;

  vga_fb_scaler_reader #(.IMG_W(IW), .IMG_H(IH), .RD_LAT(1), .BG_COLOR(BG)) dut_a (
    .clk(clk), .reset_n(reset_n), .x_coor(x_coor), .y_coor(y_coor),
    .display_en(display_en), .h_sync(h_sync), .v_sync(v_sync), .mode(mode),
    .re(re_a), .rAddr(raddr_a), .rData(rdata_a),
    .vgaRed(red_a), .vgaGreen(grn_a), .vgaBlue(blu_a),
    .h_sync_o(hso_a), .v_sync_o(vso_a)
  );

  vga_fb_scaler_reader #(.IMG_W(IW), .IMG_H(IH), .RD_LAT(3), .BG_COLOR(BG)) dut_b (
    .clk(clk), .reset_n(reset_n), .x_coor(x_coor), .y_coor(y_coor),
    .display_en(display_en), .h_sync(h_sync), .v_sync(v_sync), .mode(mode),
    .re(re_b), .rAddr(raddr_b), .rData(rdata_b),
    .vgaRed(red_b), .vgaGreen(grn_b), .vgaBlue(blu_b),
    .h_sync_o(hso_b), .v_sync_o(vso_b)
  );

  function automatic logic [11:0] pix(input int a);
    return 12'(a * 37) ^ 12'h5A3;
  endfunction

  // BRAM models: hold the read port when re is low.
  always @(posedge clk) begin
    if (re_a) rdata_a <= pix(int'(raddr_a));
    if (re_b) p3[0] <= pix(int'(raddr_b));
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rdata_b = p3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_a"}, {re_a, raddr_a, red_a, grn_a, blu_a, hso_a, vso_a}, 32'd0);
    chk({tag, "_b"}, {re_b, raddr_b, red_b, grn_b, blu_b, hso_b, vso_b}, 32'd0);
  endtask

  // A cleared delay pipe looks like LA/LB cycles of all-zero output.
  task automatic reset_queues();
    qa.delete();
    qb.delete();
    repeat (LA) qa.push_back('0);
    repeat (LB) qb.push_back('0);
  endtask

  task automatic tick(input int x, input int y, input logic de, input logic hs, input logic vs);
    exp_t e, ea, eb;
    logic act;
    int   addr, s;
    x_coor = 10'(x);
    y_coor = 9'(y);
    display_en = de;
    h_sync = hs;
    v_sync = vs;
    act = 1'b0;
    addr = 0;
    s = 1;
    e = '0;
    if (!reset_n) begin
      synced_m = 1'b0;
      mode_m = 1'b0;
    end else begin
      if (de && x == 0 && y == 0) begin
        mode_m = mode;
        synced_m = 1'b1;
      end
      s = mode_m ? 2 : 1;
      act = de && synced_m && (x < s*IW) && (y < s*IH);
      addr = mode_m ? (y/2)*IW + x/2 : y*IW + x;
      e.rgb = act ? pix(addr) : ((de && synced_m) ? BG : 12'h000);
      e.hs = hs;
      e.vs = vs;
    end
    qa.push_back(e);
    qb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    chk("re_a", 32'(re_a), 32'(act));
    chk("re_b", 32'(re_b), 32'(act));
    chk("raddr_a", 32'(raddr_a), act ? 32'(addr) : 32'd0);
    chk("raddr_b", 32'(raddr_b), act ? 32'(addr) : 32'd0);
    if (act && !mode_m && x == IW-1 && y == 0) chk("pt_1x_end_line0", 32'(raddr_a), 32'(IW-1));
    if (act && !mode_m && x == 0 && y == 1) chk("pt_1x_line1", 32'(raddr_a), 32'(IW));
    if (act && mode_m && x == 3 && y == 1) chk("pt_2x_col3_line1", 32'(raddr_a), 32'd1);
    if (act && mode_m && x == 0 && y == 2) chk("pt_2x_line2", 32'(raddr_a), 32'(IW));
    if (act && x == s*IW-1 && y == s*IH-1) chk("pt_last", 32'(raddr_b), 32'(IW*IH-1));
    if (qa.size() > LA) begin
      ea = qa.pop_front();
      chk("rgb_a", 32'({red_a, grn_a, blu_a}), 32'(ea.rgb));
      chk("sync_a", 32'({hso_a, vso_a}), 32'({ea.hs, ea.vs}));
    end
    if (qb.size() > LB) begin
      eb = qb.pop_front();
      chk("rgb_b", 32'({red_b, grn_b, blu_b}), 32'(eb.rgb));
      chk("sync_b", 32'({hso_b, vso_b}), 32'({eb.hs, eb.vs}));
    end
    if (rst_cnt > 0) begin
      rst_cnt--;
      if (rst_cnt == 0) reset_n = 1'b1;
    end
  endtask

  task automatic line(input int y, input int rx, input int ry);
    int extra [3];
    extra = '{2*IW, 400, 639};
    for (int x = 0; x < 2*IW; x++) begin
      if (x == rx && y == ry) begin
        reset_n = 1'b0;
        #1;
        outs_zero("async_reset");
        reset_queues();
        rst_cnt = 5;
      end
      tick(x, y, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) tick(extra[i], y, 1'b1, 1'b0, 1'b0);
    tick(700, y, 1'b0, 1'b1, 1'b0);
    tick(720, y, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic frame(input int rx, input int ry, input int sw_y);
    for (int y = 0; y < 2*IH; y++) begin
      if (y == sw_y) mode = 1'b1;
      line(y, rx, ry);
    end
    line(100, -1, -1);
    line(V_ACTIVE - 1, -1, -1);
    tick(0, 490, 1'b0, 1'b0, 1'b1);
    tick(5, 490, 1'b0, 1'b1, 1'b1);
    tick(H_ACTIVE + 60, 490, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    x_coor = '0;
    y_coor = '0;
    display_en = 1'b0;
    h_sync = 1'b1;
    v_sync = 1'b1;
    mode = 1'b0;
    repeat (3) @(negedge clk);
    outs_zero("reset_state");
    reset_n = 1'b1;
    reset_queues();

    // Visible pixels before any frame start are ignored.
    tick(5, 5, 1'b1, 1'b0, 1'b0);
    tick(3, 0, 1'b1, 1'b1, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 1'b1);

    frame(-1, -1, -1);
    mode = 1'b1;
    frame(-1, -1, -1);
    mode = 1'b0;
    frame(-1, -1, 10);
    frame(-1, -1, -1);
    frame(20, 5, -1);
    mode = 1'b0;
    frame(-1, -1, -1);

    for (int i = 0; i < LB + 2; i++) tick(800, 500, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
